// File: rtl/reg_rename_file_pkg.sv
// Shared definitions for the architectural register file / rename-status table.
// Holds the default geometry used by reg_rename_file and rrf_commit_merge and the
// per-register rename-status entry type.
package reg_rename_file_pkg;

   localparam int unsigned DefXlen    = 32;
   localparam int unsigned DefNreg    = 32;
   localparam int unsigned DefTagW    = 4;
   localparam int unsigned DefAw      = $clog2(DefNreg);
   localparam int unsigned DefRdPorts = 2;
   localparam int unsigned DefNCmt    = 2;

   typedef logic [DefTagW-1:0] tag_t;

   // One rename-table slot: producing RoB tag and pending flag.
   typedef struct packed {
      tag_t tag;
      logic busy;
   } rat_entry_t;

endpackage

// File: rtl/rrf_commit_merge.sv
// Per-register priority merge of all commit channels.
// For every architectural register (1..NREG-1) it reports whether any active channel
// writes it, the value of the youngest (highest-index) channel writing it, and whether
// that youngest channel's tag equals the stored tag (clears busy). It also exports the
// raw per-channel tag match so the read bypass uses the same comparison.
// Ports:
//   cmt_rd_in   commit destination per channel (0 = idle)
//   cmt_tag_in  RoB tag per channel
//   cmt_val_in  committed value per channel
//   tag_in      stored tag of every register, flattened
//   we_out      per register: some channel writes it
//   val_out     per register: value from youngest writing channel
//   clr_out     per register: youngest writing channel carries the stored tag
//   hit_out     [c*NREG + r]: channel c targets r with the stored tag of r
module rrf_commit_merge
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = DefXlen,
   parameter int unsigned NREG  = DefNreg,
   parameter int unsigned TAG_W = DefTagW,
   parameter int unsigned N_CMT = DefNCmt,
   parameter int unsigned AW    = DefAw
) (
   input  logic [N_CMT*AW-1:0]    cmt_rd_in,
   input  logic [N_CMT*TAG_W-1:0] cmt_tag_in,
   input  logic [N_CMT*XLEN-1:0]  cmt_val_in,
   input  logic [NREG*TAG_W-1:0]  tag_in,
   output logic [NREG-1:0]        we_out,
   output logic [NREG*XLEN-1:0]   val_out,
   output logic [NREG-1:0]        clr_out,
   output logic [N_CMT*NREG-1:0]  hit_out
);

   always_comb begin
      we_out  = '0;
      val_out = '0;
      clr_out = '0;
      hit_out = '0;
      // Register 0 is never written, so the loop starts at 1.
      for (int r = 1; r < NREG; r++) begin
         // Ascending channel order: later (younger) channels overwrite older ones.
         for (int c = 0; c < N_CMT; c++) begin
            if (cmt_rd_in[c*AW +: AW] == AW'(r)) begin
               we_out[r]                = 1'b1;
               val_out[r*XLEN +: XLEN]  = cmt_val_in[c*XLEN +: XLEN];
               clr_out[r]               = (cmt_tag_in[c*TAG_W +: TAG_W] ==
                                           tag_in[r*TAG_W +: TAG_W]);
               hit_out[c*NREG + r]      = (cmt_tag_in[c*TAG_W +: TAG_W] ==
                                           tag_in[r*TAG_W +: TAG_W]);
            end
         end
      end
   end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename-status table (RoB tag + busy per register).
// Issue reads operands and renames a destination; RoB commit retires values.
// Ports:
//   clk_in        clock
//   rst_n_in      asynchronous active-low reset
//   rdy_in        state update enable (reads and bypass stay live when low)
//   flush_in      drop all renames; values kept
//   iss_rd_in     rename destination (0 = none), iss_tag_in its RoB tag
//   cmt_rd_in     commit destination per channel (0 = idle), channel 0 oldest
//   cmt_tag_in    RoB tag per commit channel
//   cmt_val_in    committed value per channel
//   rd_addr_in    operand read addresses
//   rd_val_out    operand value (commit-bypassed)
//   rd_tag_out    producing tag (meaningful when busy)
//   rd_busy_out   value still pending in the RoB
//   busy_cnt_out  number of busy registers (registered)
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN     = DefXlen,
   parameter int unsigned NREG     = DefNreg,
   parameter int unsigned TAG_W    = DefTagW,
   parameter int unsigned RD_PORTS = DefRdPorts,
   parameter int unsigned N_CMT    = DefNCmt,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      rdy_in,
   input  logic                      flush_in,
   input  logic [AW-1:0]             iss_rd_in,
   input  logic [TAG_W-1:0]          iss_tag_in,
   input  logic [N_CMT*AW-1:0]       cmt_rd_in,
   input  logic [N_CMT*TAG_W-1:0]    cmt_tag_in,
   input  logic [N_CMT*XLEN-1:0]     cmt_val_in,
   input  logic [RD_PORTS*AW-1:0]    rd_addr_in,
   output logic [RD_PORTS*XLEN-1:0]  rd_val_out,
   output logic [RD_PORTS*TAG_W-1:0] rd_tag_out,
   output logic [RD_PORTS-1:0]       rd_busy_out,
   output logic [AW:0]               busy_cnt_out
);

   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [TAG_W-1:0] tag_q [NREG];
   logic [TAG_W-1:0] tag_d [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;

   logic [NREG*TAG_W-1:0] tag_flat;
   logic [NREG-1:0]       cm_we;
   logic [NREG*XLEN-1:0]  cm_val;
   logic [NREG-1:0]       cm_clr;
   logic [N_CMT*NREG-1:0] cm_hit;
   logic [AW-1:0]         rd_addr [RD_PORTS];

   always_comb begin
      tag_flat = '0;
      for (int r = 0; r < NREG; r++) begin
         tag_flat[r*TAG_W +: TAG_W] = tag_q[r];
      end
   end

   rrf_commit_merge #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W),
      .N_CMT (N_CMT),
      .AW    (AW)
   ) u_commit_merge (
      .cmt_rd_in  (cmt_rd_in),
      .cmt_tag_in (cmt_tag_in),
      .cmt_val_in (cmt_val_in),
      .tag_in     (tag_flat),
      .we_out     (cm_we),
      .val_out    (cm_val),
      .clr_out    (cm_clr),
      .hit_out    (cm_hit)
   );

   // Next state. Register 0 keeps its reset contents (all zero) forever.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         val_d[r] = val_q[r];
         tag_d[r] = tag_q[r];
      end
      busy_d = busy_q;
      for (int r = 1; r < NREG; r++) begin
         // Commits always deliver their value, even under flush or a same-cycle rename.
         if (cm_we[r]) begin
            val_d[r] = cm_val[r*XLEN +: XLEN];
         end
         if (flush_in) begin
            tag_d[r]  = '0;
            busy_d[r] = 1'b0;
         end else if (iss_rd_in == AW'(r)) begin
            tag_d[r]  = iss_tag_in;
            busy_d[r] = 1'b1;
         end else if (cm_clr[r]) begin
            busy_d[r] = 1'b0;
         end
      end
      // The counter tracks the population of the next busy vector, which covers the
      // re-rename, issue-over-commit and flush cases without separate bookkeeping.
      cnt_d = '0;
      for (int r = 1; r < NREG; r++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int r = 0; r < NREG; r++) begin
            val_q[r] <= '0;
            tag_q[r] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else if (rdy_in) begin
         for (int r = 0; r < NREG; r++) begin
            val_q[r] <= val_d[r];
            tag_q[r] <= tag_d[r];
         end
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt_out = cnt_q;

   always_comb begin
      for (int p = 0; p < RD_PORTS; p++) begin
         rd_addr[p] = rd_addr_in[p*AW +: AW];
      end
   end

   // Reads see pre-issue state; a matching commit forwards its value and clears busy.
   // Bypass is independent of rdy_in.
   always_comb begin
      rd_val_out  = '0;
      rd_tag_out  = '0;
      rd_busy_out = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         if (rd_addr[p] != '0 && int'(rd_addr[p]) < NREG) begin
            rd_val_out[p*XLEN +: XLEN]   = val_q[rd_addr[p]];
            rd_tag_out[p*TAG_W +: TAG_W] = tag_q[rd_addr[p]];
            rd_busy_out[p]               = busy_q[rd_addr[p]];
            for (int c = 0; c < N_CMT; c++) begin
               if (cm_hit[c*NREG + int'(rd_addr[p])]) begin
                  rd_val_out[p*XLEN +: XLEN] = cmt_val_in[c*XLEN +: XLEN];
                  rd_busy_out[p]             = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios, a behavioural rename-table model
// checked on every negative clock edge, and literal expectations per scenario.
module tb_reg_rename_file;
   import reg_rename_file_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rdy;
   logic        flush;
   logic [4:0]  iss_rd;
   logic [3:0]  iss_tag;
   logic [4:0]  c_rd [2];
   logic [3:0]  c_tag [2];
   logic [31:0] c_val [2];
   logic [4:0]  r_addr [2];

   logic [9:0]  cmt_rd_f;
   logic [7:0]  cmt_tag_f;
   logic [63:0] cmt_val_f;
   logic [9:0]  rd_addr_f;
   logic [63:0] rd_val;
   logic [7:0]  rd_tag;
   logic [1:0]  rd_busy;
   logic [5:0]  busy_cnt;

   assign cmt_rd_f  = {c_rd[1], c_rd[0]};
   assign cmt_tag_f = {c_tag[1], c_tag[0]};
   assign cmt_val_f = {c_val[1], c_val[0]};
   assign rd_addr_f = {r_addr[1], r_addr[0]};

   reg_rename_file dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .rdy_in       (rdy),
      .flush_in     (flush),
      .iss_rd_in    (iss_rd),
      .iss_tag_in   (iss_tag),
      .cmt_rd_in    (cmt_rd_f),
      .cmt_tag_in   (cmt_tag_f),
      .cmt_val_in   (cmt_val_f),
      .rd_addr_in   (rd_addr_f),
      .rd_val_out   (rd_val),
      .rd_tag_out   (rd_tag),
      .rd_busy_out  (rd_busy),
      .busy_cnt_out (busy_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_val [32];
   rat_entry_t  m_rat [32];
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_rat[i] = '0;
         end
         m_cnt = 0;
      end else if (rdy) begin : step
         logic [31:0] nv [32];
         logic [3:0]  lt [32];
         logic        hs [32];
         int          inc;
         int          dec;
         inc = 0;
         dec = 0;
         for (int i = 0; i < 32; i++) begin
            hs[i] = 1'b0;
            nv[i] = '0;
            lt[i] = '0;
         end
         // Last (youngest) commit to a register decides both value and tag.
         for (int c = 0; c < 2; c++) begin
            if (c_rd[c] != 0) begin
               hs[c_rd[c]] = 1'b1;
               nv[c_rd[c]] = c_val[c];
               lt[c_rd[c]] = c_tag[c];
            end
         end
         for (int r = 1; r < 32; r++) begin
            if (hs[r]) m_val[r] = nv[r];
         end
         if (flush) begin
            for (int r = 0; r < 32; r++) m_rat[r] = '0;
            m_cnt = 0;
         end else begin
            for (int r = 1; r < 32; r++) begin
               if (hs[r] && lt[r] == m_rat[r].tag && m_rat[r].busy && r != int'(iss_rd)) begin
                  m_rat[r].busy = 1'b0;
                  dec++;
               end
            end
            if (iss_rd != 0) begin
               if (!m_rat[iss_rd].busy) inc = 1;
               m_rat[iss_rd].tag  = iss_tag;
               m_rat[iss_rd].busy = 1'b1;
            end
            m_cnt = m_cnt + inc - dec;
         end
      end
   end

   task automatic model_read(input logic [4:0] a, output logic [31:0] v, output logic [3:0] t,
                             output logic b);
      v = '0;
      t = '0;
      b = 1'b0;
      if (a != 0) begin
         v = m_val[a];
         t = m_rat[a].tag;
         b = m_rat[a].busy;
         for (int c = 0; c < 2; c++) begin
            if (c_rd[c] == a && c_tag[c] == m_rat[a].tag) begin
               v = c_val[c];
               b = 1'b0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         for (int p = 0; p < 2; p++) begin
            logic [31:0] ev;
            logic [3:0]  et;
            logic        eb;
            model_read(r_addr[p], ev, et, eb);
            chk($sformatf("model val p%0d", p), rd_val[p*32 +: 32], ev);
            chk($sformatf("model busy p%0d", p), 32'(rd_busy[p]), 32'(eb));
            if (eb || r_addr[p] == 0) begin
               chk($sformatf("model tag p%0d", p), 32'(rd_tag[p*4 +: 4]), 32'(et));
            end
         end
         chk("model busy_cnt", 32'(busy_cnt), 32'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      flush  = 1'b0;
      iss_rd = '0;
      iss_tag = '0;
      for (int c = 0; c < 2; c++) begin
         c_rd[c]  = '0;
         c_tag[c] = '0;
         c_val[c] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rdy = 1'b1;
      r_addr[0] = 5'd5;
      r_addr[1] = 5'd7;
      #1 rst_n = 1'b0;
      #2;
      chk("reset val p0", rd_val[31:0], 32'h0);
      chk("reset busy", 32'(rd_busy), 32'h0);
      chk("reset cnt", 32'(busy_cnt), 32'h0);
      #9 rst_n = 1'b1;
      tick();
      chk_en = 1'b1;

      // Rename r5 then commit its matching tag; same-cycle bypass.
      iss_rd = 5'd5; iss_tag = 4'd3; r_addr[0] = 5'd5;
      #1 chk("s1 pre-issue busy", 32'(rd_busy[0]), 32'h0);
      tick(); idle();
      c_rd[0] = 5'd5; c_tag[0] = 4'd3; c_val[0] = 32'hDEAD;
      #1;
      chk("s1 bypass val", rd_val[31:0], 32'hDEAD);
      chk("s1 bypass busy", 32'(rd_busy[0]), 32'h0);
      chk("s1 cnt before", 32'(busy_cnt), 32'd1);
      tick(); idle();
      #1;
      chk("s1 stored val", rd_val[31:0], 32'hDEAD);
      chk("s1 stored busy", 32'(rd_busy[0]), 32'h0);
      chk("s1 cnt after", 32'(busy_cnt), 32'd0);

      // Stale commit to a re-renamed register.
      r_addr[1] = 5'd7;
      iss_rd = 5'd7; iss_tag = 4'd2;
      tick();
      iss_rd = 5'd7; iss_tag = 4'd9;
      tick(); idle();
      c_rd[0] = 5'd7; c_tag[0] = 4'd2; c_val[0] = 32'h11;
      #1 chk("s2 no bypass busy", 32'(rd_busy[1]), 32'h1);
      tick(); idle();
      #1;
      chk("s2 val", rd_val[63:32], 32'h11);
      chk("s2 busy", 32'(rd_busy[1]), 32'h1);
      chk("s2 tag", 32'(rd_tag[7:4]), 32'd9);
      chk("s2 cnt", 32'(busy_cnt), 32'd1);

      // Same-cycle issue and commit of the old tag on r4.
      r_addr[0] = 5'd4;
      iss_rd = 5'd4; iss_tag = 4'd1;
      tick();
      iss_rd = 5'd4; iss_tag = 4'd6;
      c_rd[0] = 5'd4; c_tag[0] = 4'd1; c_val[0] = 32'h44;
      tick(); idle();
      #1;
      chk("s3 val", rd_val[31:0], 32'h44);
      chk("s3 busy", 32'(rd_busy[0]), 32'h1);
      chk("s3 tag", 32'(rd_tag[3:0]), 32'd6);
      chk("s3 cnt", 32'(busy_cnt), 32'd2);

      // Dual commit to r3, youngest holds the stored tag.
      r_addr[0] = 5'd3;
      iss_rd = 5'd3; iss_tag = 4'd2;
      tick(); idle();
      c_rd[0] = 5'd3; c_tag[0] = 4'd1; c_val[0] = 32'hA;
      c_rd[1] = 5'd3; c_tag[1] = 4'd2; c_val[1] = 32'hB;
      #1 chk("s4 bypass val", rd_val[31:0], 32'hB);
      tick(); idle();
      #1;
      chk("s4 val", rd_val[31:0], 32'hB);
      chk("s4 busy", 32'(rd_busy[0]), 32'h0);
      chk("s4 cnt", 32'(busy_cnt), 32'd2);

      // Flush scenario, first frozen by rdy_in=0, then live.
      iss_rd = 5'd2; iss_tag = 4'd5;
      tick(); idle();
      #1 chk("s5 cnt three", 32'(busy_cnt), 32'd3);
      r_addr[0] = 5'd2; r_addr[1] = 5'd9;
      rdy = 1'b0; flush = 1'b1;
      iss_rd = 5'd9; iss_tag = 4'd8;
      c_rd[0] = 5'd2; c_tag[0] = 4'd5; c_val[0] = 32'h77;
      #1 chk("s5 frozen bypass", rd_val[31:0], 32'h77);
      tick(); idle();
      rdy = 1'b1;
      #1;
      chk("s5 frozen val", rd_val[31:0], 32'h0);
      chk("s5 frozen busy r2", 32'(rd_busy[0]), 32'h1);
      chk("s5 frozen busy r9", 32'(rd_busy[1]), 32'h0);
      chk("s5 frozen cnt", 32'(busy_cnt), 32'd3);
      flush = 1'b1;
      iss_rd = 5'd9; iss_tag = 4'd8;
      c_rd[0] = 5'd2; c_tag[0] = 4'd5; c_val[0] = 32'h77;
      tick(); idle();
      #1;
      chk("s5 r2 val", rd_val[31:0], 32'h77);
      chk("s5 r2 busy", 32'(rd_busy[0]), 32'h0);
      chk("s5 r9 busy", 32'(rd_busy[1]), 32'h0);
      chk("s5 cnt", 32'(busy_cnt), 32'd0);
      r_addr[0] = 5'd7;
      #1 chk("s5 r7 kept", rd_val[31:0], 32'h11);

      // Register 0 ignores both paths.
      r_addr[0] = 5'd0;
      iss_rd = 5'd0; iss_tag = 4'd7;
      c_rd[1] = 5'd0; c_tag[1] = 4'd0; c_val[1] = 32'h99;
      #1 chk("r0 val", rd_val[31:0], 32'h0);
      tick(); idle();
      #1 chk("r0 cnt", 32'(busy_cnt), 32'd0);

      // Re-renaming a busy register does not increment the count.
      r_addr[0] = 5'd6;
      iss_rd = 5'd6; iss_tag = 4'd1;
      tick();
      iss_rd = 5'd6; iss_tag = 4'd2;
      tick(); idle();
      #1 chk("rerename cnt", 32'(busy_cnt), 32'd1);

      // Mid-cycle asynchronous reset.
      iss_rd = 5'd8; iss_tag = 4'd3;
      c_rd[0] = 5'd5; c_tag[0] = 4'd0; c_val[0] = 32'h55;
      tick(); idle();
      r_addr[0] = 5'd5; r_addr[1] = 5'd8;
      #1;
      chk("pre-reset r5", rd_val[31:0], 32'h55);
      chk("pre-reset cnt", 32'(busy_cnt), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset val", rd_val[31:0], 32'h0);
      chk("async reset busy", 32'(rd_busy), 32'h0);
      chk("async reset cnt", 32'(busy_cnt), 32'd0);
      chk_en = 1'b0;
      #10 rst_n = 1'b1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
